// File: rtl/reservation_station.sv
// Reservation station for ALU-class instructions. It holds dispatched entries until both
// operands are ready, wakes them from CDB/LDB broadcasts, and issues one entry per cycle.
module reservation_station #(
  parameter int unsigned RS_N    = 8,
  parameter int unsigned ROB_BIT = 4,
  parameter int unsigned DAT_W   = 32,
  parameter int unsigned OP_W    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               br_flag,
  input  logic               rf_en_i,
  input  logic               rf_ic_i,
  input  logic [OP_W-1:0]    rf_op_i,
  input  logic [DAT_W-1:0]   rf_imm_i,
  input  logic [ROB_BIT-1:0] rf_qj_i,
  input  logic [ROB_BIT-1:0] rf_qk_i,
  input  logic [DAT_W-1:0]   rf_vj_i,
  input  logic [DAT_W-1:0]   rf_vk_i,
  input  logic [ROB_BIT-1:0] rf_qd_i,
  input  logic [DAT_W-1:0]   rf_pc_i,
  input  logic               cdb_en_i,
  input  logic [ROB_BIT-1:0] cdb_q_i,
  input  logic [DAT_W-1:0]   cdb_v_i,
  input  logic               ldb_en_i,
  input  logic [ROB_BIT-1:0] ldb_q_i,
  input  logic [DAT_W-1:0]   ldb_v_i,
  output logic               full_o,
  output logic               alu_en_o,
  output logic               alu_ic_o,
  output logic [OP_W-1:0]    alu_op_o,
  output logic [DAT_W-1:0]   alu_vj_o,
  output logic [DAT_W-1:0]   alu_vk_o,
  output logic [DAT_W-1:0]   alu_imm_o,
  output logic [DAT_W-1:0]   alu_pc_o,
  output logic [ROB_BIT-1:0] alu_qd_o
);

  localparam int unsigned IdxW = $clog2(RS_N);
  localparam int unsigned CntW = IdxW + 1;
  localparam logic [CntW-1:0] FullThr = CntW'(RS_N - 1);

  typedef struct packed {
    logic               ic;
    logic [OP_W-1:0]    op;
    logic [DAT_W-1:0]   imm;
    logic [ROB_BIT-1:0] qj;
    logic [ROB_BIT-1:0] qk;
    logic [DAT_W-1:0]   vj;
    logic [DAT_W-1:0]   vk;
    logic [ROB_BIT-1:0] qd;
    logic [DAT_W-1:0]   pc;
  } entry_t;

  logic [RS_N-1:0] valid_q, valid_d;
  entry_t          ent_q [RS_N];
  entry_t          ent_d [RS_N];
  logic            full_q, full_d;
  logic            alu_en_q, alu_en_d;
  entry_t          alu_ent_q, alu_ent_d;

  logic [RS_N-1:0] ready, free;
  logic            issue_any, ins_any;
  logic [IdxW-1:0] issue_idx, ins_idx;
  entry_t          new_ent;
  logic [CntW-1:0] cnt_d;

  always_comb begin
    for (int i = 0; i < RS_N; i++) begin
      ready[i] = valid_q[i] && (ent_q[i].qj == '0) && (ent_q[i].qk == '0);
    end
  end

  // Downward scan so the last hit is the lowest index.
  always_comb begin
    issue_any = 1'b0;
    issue_idx = '0;
    for (int i = int'(RS_N) - 1; i >= 0; i--) begin
      if (ready[i]) begin
        issue_any = 1'b1;
        issue_idx = IdxW'(i);
      end
    end
  end

  // The entry leaving this cycle counts as free for the incoming dispatch.
  always_comb begin
    for (int i = 0; i < RS_N; i++) begin
      free[i] = !valid_q[i] || (issue_any && (issue_idx == IdxW'(i)));
    end
    ins_any = 1'b0;
    ins_idx = '0;
    for (int i = int'(RS_N) - 1; i >= 0; i--) begin
      if (free[i]) begin
        ins_any = 1'b1;
        ins_idx = IdxW'(i);
      end
    end
  end

  // Dispatch-time bypass; the LDB check comes last so it wins a double match.
  always_comb begin
    new_ent    = '{ic: rf_ic_i, op: rf_op_i, imm: rf_imm_i, qj: rf_qj_i, qk: rf_qk_i,
                   vj: rf_vj_i, vk: rf_vk_i, qd: rf_qd_i, pc: rf_pc_i};
    if (rf_qj_i != '0) begin
      if (cdb_en_i && (cdb_q_i == rf_qj_i)) begin
        new_ent.vj = cdb_v_i;
        new_ent.qj = '0;
      end
      if (ldb_en_i && (ldb_q_i == rf_qj_i)) begin
        new_ent.vj = ldb_v_i;
        new_ent.qj = '0;
      end
    end
    if (rf_qk_i != '0) begin
      if (cdb_en_i && (cdb_q_i == rf_qk_i)) begin
        new_ent.vk = cdb_v_i;
        new_ent.qk = '0;
      end
      if (ldb_en_i && (ldb_q_i == rf_qk_i)) begin
        new_ent.vk = ldb_v_i;
        new_ent.qk = '0;
      end
    end
  end

  always_comb begin
    valid_d   = valid_q;
    ent_d     = ent_q;
    alu_en_d  = 1'b0;
    alu_ent_d = alu_ent_q;
    if (br_flag) begin
      valid_d = '0;
    end else if (en) begin
      for (int i = 0; i < RS_N; i++) begin
        if (valid_q[i] && (ent_q[i].qj != '0)) begin
          if (cdb_en_i && (cdb_q_i == ent_q[i].qj)) begin
            ent_d[i].vj = cdb_v_i;
            ent_d[i].qj = '0;
          end
          if (ldb_en_i && (ldb_q_i == ent_q[i].qj)) begin
            ent_d[i].vj = ldb_v_i;
            ent_d[i].qj = '0;
          end
        end
        if (valid_q[i] && (ent_q[i].qk != '0)) begin
          if (cdb_en_i && (cdb_q_i == ent_q[i].qk)) begin
            ent_d[i].vk = cdb_v_i;
            ent_d[i].qk = '0;
          end
          if (ldb_en_i && (ldb_q_i == ent_q[i].qk)) begin
            ent_d[i].vk = ldb_v_i;
            ent_d[i].qk = '0;
          end
        end
      end
      if (issue_any) begin
        valid_d[issue_idx] = 1'b0;
        alu_en_d           = 1'b1;
        alu_ent_d          = ent_q[issue_idx];
      end
      // With no free slot the dispatch is dropped and nothing is overwritten.
      if (rf_en_i && ins_any) begin
        valid_d[ins_idx] = 1'b1;
        ent_d[ins_idx]   = new_ent;
      end
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < RS_N; i++) begin
      cnt_d = cnt_d + CntW'(valid_d[i]);
    end
    full_d = (cnt_d >= FullThr);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q   <= '0;
      full_q    <= 1'b0;
      alu_en_q  <= 1'b0;
      alu_ent_q <= '0;
    end else begin
      valid_q   <= valid_d;
      full_q    <= full_d;
      alu_en_q  <= alu_en_d;
      alu_ent_q <= alu_ent_d;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign full_o    = full_q;
  assign alu_en_o  = alu_en_q;
  assign alu_ic_o  = alu_ent_q.ic;
  assign alu_op_o  = alu_ent_q.op;
  assign alu_vj_o  = alu_ent_q.vj;
  assign alu_vk_o  = alu_ent_q.vk;
  assign alu_imm_o = alu_ent_q.imm;
  assign alu_pc_o  = alu_ent_q.pc;
  assign alu_qd_o  = alu_ent_q.qd;

endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for reservation_station: dispatch, wakeup, bypass, fill,
// flush, reset and stall, with hand-computed expected values.
module tb_reservation_station;

  logic        clk = 1'b0;
  logic        rst, en, br_flag;
  logic        rf_en_i, rf_ic_i;
  logic [5:0]  rf_op_i;
  logic [31:0] rf_imm_i, rf_vj_i, rf_vk_i, rf_pc_i;
  logic [3:0]  rf_qj_i, rf_qk_i, rf_qd_i;
  logic        cdb_en_i, ldb_en_i;
  logic [3:0]  cdb_q_i, ldb_q_i;
  logic [31:0] cdb_v_i, ldb_v_i;
  logic        full_o, alu_en_o, alu_ic_o;
  logic [5:0]  alu_op_o;
  logic [31:0] alu_vj_o, alu_vk_o, alu_imm_o, alu_pc_o;
  logic [3:0]  alu_qd_o;

  int n_pass = 0;
  int n_total = 0;

  reservation_station dut (
    .clk(clk), .rst(rst), .en(en), .br_flag(br_flag),
    .rf_en_i(rf_en_i), .rf_ic_i(rf_ic_i), .rf_op_i(rf_op_i), .rf_imm_i(rf_imm_i),
    .rf_qj_i(rf_qj_i), .rf_qk_i(rf_qk_i), .rf_vj_i(rf_vj_i), .rf_vk_i(rf_vk_i),
    .rf_qd_i(rf_qd_i), .rf_pc_i(rf_pc_i),
    .cdb_en_i(cdb_en_i), .cdb_q_i(cdb_q_i), .cdb_v_i(cdb_v_i),
    .ldb_en_i(ldb_en_i), .ldb_q_i(ldb_q_i), .ldb_v_i(ldb_v_i),
    .full_o(full_o), .alu_en_o(alu_en_o), .alu_ic_o(alu_ic_o), .alu_op_o(alu_op_o),
    .alu_vj_o(alu_vj_o), .alu_vk_o(alu_vk_o), .alu_imm_o(alu_imm_o), .alu_pc_o(alu_pc_o),
    .alu_qd_o(alu_qd_o)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic disp(input logic [3:0] qj, input logic [31:0] vj, input logic [3:0] qk,
                      input logic [31:0] vk, input logic [3:0] qd);
    rf_en_i  = 1'b1;
    rf_ic_i  = qd[0];
    rf_op_i  = {2'b00, qd};
    rf_imm_i = 32'h1000 + {28'h0, qd};
    rf_pc_i  = 32'h400 + {26'h0, qd, 2'b00};
    rf_qj_i  = qj;
    rf_vj_i  = vj;
    rf_qk_i  = qk;
    rf_vk_i  = vk;
    rf_qd_i  = qd;
  endtask

  task automatic idle();
    rf_en_i  = 1'b0;
    cdb_en_i = 1'b0;
    ldb_en_i = 1'b0;
    br_flag  = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; br_flag = 1'b0;
    rf_en_i = 1'b0; rf_ic_i = 1'b0; rf_op_i = '0; rf_imm_i = '0; rf_vj_i = '0;
    rf_vk_i = '0; rf_pc_i = '0; rf_qj_i = '0; rf_qk_i = '0; rf_qd_i = '0;
    cdb_en_i = 1'b0; cdb_q_i = '0; cdb_v_i = '0;
    ldb_en_i = 1'b0; ldb_q_i = '0; ldb_v_i = '0;
    tick(); tick();
    chk("reset_alu_en", 32'(alu_en_o), 32'd0);
    chk("reset_full", 32'(full_o), 32'd0);
    chk("reset_alu_vj", alu_vj_o, 32'd0);
    chk("reset_alu_qd", 32'(alu_qd_o), 32'd0);
    rst = 1'b1;

    // Ready dispatch: issues one edge after insert.
    disp(4'd0, 32'd5, 4'd0, 32'd7, 4'd3);
    tick(); idle();
    chk("ready_no_issue_at_insert", 32'(alu_en_o), 32'd0);
    tick();
    chk("ready_alu_en", 32'(alu_en_o), 32'd1);
    chk("ready_vj", alu_vj_o, 32'd5);
    chk("ready_vk", alu_vk_o, 32'd7);
    chk("ready_qd", 32'(alu_qd_o), 32'd3);
    chk("ready_op", 32'(alu_op_o), 32'h03);
    chk("ready_ic", 32'(alu_ic_o), 32'd1);
    chk("ready_imm", alu_imm_o, 32'h1003);
    chk("ready_pc", alu_pc_o, 32'h40c);
    tick();
    chk("ready_pulse_ends", 32'(alu_en_o), 32'd0);
    chk("ready_data_holds", alu_vj_o, 32'd5);

    // Wakeup through the CDB.
    disp(4'd2, 32'd0, 4'd0, 32'd1, 4'd4);
    tick(); idle();
    chk("wake_wait1", 32'(alu_en_o), 32'd0);
    tick();
    chk("wake_wait2", 32'(alu_en_o), 32'd0);
    tick();
    chk("wake_wait3", 32'(alu_en_o), 32'd0);
    cdb_en_i = 1'b1; cdb_q_i = 4'd2; cdb_v_i = 32'h10;
    tick(); idle();
    chk("wake_no_issue_on_capture", 32'(alu_en_o), 32'd0);
    tick();
    chk("wake_alu_en", 32'(alu_en_o), 32'd1);
    chk("wake_vj", alu_vj_o, 32'h10);
    chk("wake_vk", alu_vk_o, 32'd1);
    chk("wake_qd", 32'(alu_qd_o), 32'd4);
    tick();
    chk("wake_pulse_ends", 32'(alu_en_o), 32'd0);

    // LDB bypass at insert.
    disp(4'd4, 32'd0, 4'd0, 32'd2, 4'd5);
    ldb_en_i = 1'b1; ldb_q_i = 4'd4; ldb_v_i = 32'hAB;
    tick(); idle();
    chk("byp_no_issue_at_insert", 32'(alu_en_o), 32'd0);
    tick();
    chk("byp_alu_en", 32'(alu_en_o), 32'd1);
    chk("byp_vj", alu_vj_o, 32'hAB);
    chk("byp_qd", 32'(alu_qd_o), 32'd5);
    tick();

    // Fill to RS_N-1 blocked entries, then release them all at once.
    for (int i = 0; i < 7; i++) begin
      disp(4'd9, 32'd0, 4'd0, 32'(i), 4'(i + 1));
      tick();
      chk($sformatf("fill_full_%0d", i), 32'(full_o), (i == 6) ? 32'd1 : 32'd0);
      chk($sformatf("fill_no_issue_%0d", i), 32'(alu_en_o), 32'd0);
    end
    idle();
    cdb_en_i = 1'b1; cdb_q_i = 4'd9; cdb_v_i = 32'h99;
    tick(); idle();
    chk("fill_capture_no_issue", 32'(alu_en_o), 32'd0);
    chk("fill_still_full", 32'(full_o), 32'd1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("drain_en_%0d", i), 32'(alu_en_o), 32'd1);
      chk($sformatf("drain_qd_%0d", i), 32'(alu_qd_o), 32'(i + 1));
      chk($sformatf("drain_vk_%0d", i), alu_vk_o, 32'(i));
      chk($sformatf("drain_vj_%0d", i), alu_vj_o, 32'h99);
      if (i == 0) chk("drain_full_drops", 32'(full_o), 32'd0);
    end
    tick();
    chk("drain_done", 32'(alu_en_o), 32'd0);

    // Flush discards blocked entries.
    for (int i = 0; i < 4; i++) begin
      disp(4'd9, 32'd0, 4'd0, 32'd0, 4'(8 + i));
      tick();
    end
    idle();
    br_flag = 1'b1;
    tick(); idle();
    chk("flush_alu_en", 32'(alu_en_o), 32'd0);
    chk("flush_full", 32'(full_o), 32'd0);
    cdb_en_i = 1'b1; cdb_q_i = 4'd9; cdb_v_i = 32'h55;
    tick(); idle();
    chk("flush_cdb_no_issue_a", 32'(alu_en_o), 32'd0);
    tick();
    chk("flush_cdb_no_issue_b", 32'(alu_en_o), 32'd0);
    chk("flush_full_after", 32'(full_o), 32'd0);

    // Reset mid-stream.
    disp(4'd9, 32'd0, 4'd0, 32'd0, 4'd1);
    tick();
    disp(4'd9, 32'd0, 4'd0, 32'd0, 4'd2);
    tick(); idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mrst_alu_en", 32'(alu_en_o), 32'd0);
    chk("mrst_full", 32'(full_o), 32'd0);
    chk("mrst_alu_vj", alu_vj_o, 32'd0);
    chk("mrst_alu_qd", 32'(alu_qd_o), 32'd0);
    cdb_en_i = 1'b1; cdb_q_i = 4'd9; cdb_v_i = 32'h77;
    tick(); idle();
    tick();
    chk("mrst_no_issue", 32'(alu_en_o), 32'd0);

    // Stall: a ready entry waits while en is low; a dispatch during stall is ignored.
    disp(4'd0, 32'h33, 4'd0, 32'h44, 4'd6);
    tick(); idle();
    en = 1'b0;
    disp(4'd0, 32'h66, 4'd0, 32'h77, 4'd7);
    tick(); idle();
    chk("stall_1", 32'(alu_en_o), 32'd0);
    tick();
    chk("stall_2", 32'(alu_en_o), 32'd0);
    tick();
    chk("stall_3", 32'(alu_en_o), 32'd0);
    en = 1'b1;
    tick();
    chk("resume_en", 32'(alu_en_o), 32'd1);
    chk("resume_qd", 32'(alu_qd_o), 32'd6);
    chk("resume_vj", alu_vj_o, 32'h33);
    chk("resume_vk", alu_vk_o, 32'h44);
    tick();
    chk("stall_dispatch_ignored", 32'(alu_en_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Holds ALU-class instructions dispatched by the register file stage until both source operands are available.
- Snoops the CDB (ALU results) and the LDB (load results) to wake up waiting operands.
- Each cycle, selects at most one ready entry and issues it, registered, to the ALU.
- Sits between the register file stage (upstream) and the ALU/CDB (downstream). A branch mispredict flushes it.

Parameters:
- RS_N, 8, number of entries (power of two, ≥2)
- ROB_BIT, 4, ROB tag width; tag 0 means "no dependency / value ready"
- DAT_W, 32, data width
- OP_W, 6, opcode width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- en  in  1  global enable; low = stall
- br_flag  in  1  mispredict flush
- rf_en_i  in  1  dispatch valid from register file stage
- rf_ic_i  in  1  compressed-instruction flag
- rf_op_i  in  OP_W  opcode
- rf_imm_i  in  DAT_W  immediate
- rf_qj_i / rf_qk_i  in  ROB_BIT  source tags (0 = ready)
- rf_vj_i / rf_vk_i  in  DAT_W  source values (valid when tag 0)
- rf_qd_i  in  ROB_BIT  destination ROB tag
- rf_pc_i  in  DAT_W  instruction PC
- cdb_en_i, cdb_q_i (ROB_BIT), cdb_v_i (DAT_W)  in  ALU result broadcast
- ldb_en_i, ldb_q_i (ROB_BIT), ldb_v_i (DAT_W)  in  load result broadcast
- full_o  out  1  no room for a further dispatch
- alu_en_o  out  1  issue valid, one-cycle pulse per instruction
- alu_ic_o  out  1  issued instruction's compressed flag
- alu_op_o  out  OP_W  issued opcode
- alu_vj_o / alu_vk_o  out  DAT_W  issued operand values
- alu_imm_o  out  DAT_W  issued immediate
- alu_pc_o  out  DAT_W  issued PC
- alu_qd_o  out  ROB_BIT  issued destination tag

Behaviour:
- Reset (rst==0 at posedge):
  - all entry valid bits cleared;
  - alu_en_o=0; all alu_*_o=0;
  - full_o=0.
  - Reset mid-operation discards every entry.
- Priority: rst > br_flag > en.
  - br_flag=1: clear all valid bits and alu_en_o; no dispatch accepted or issue performed this cycle.
  - en=0: all state held, alu_en_o<=0, inputs ignored.
- Entry fields: valid, ic, op, imm, qj, qk, vj, vk, qd, pc. An entry is ready when valid && qj==0 && qk==0.
- Dispatch: when rf_en_i=1, write to the lowest-index free entry.
  - Free entries include an entry issued in this same cycle, as seen before the update.
  - Same-cycle bypass at insert: if a CDB or LDB broadcast is valid and its tag equals a nonzero rf_qj_i, store its value and set qj=0; likewise for qk.
  - If both CDB and LDB match, LDB wins (the tags cannot legally both match).
- Wakeup: every valid entry compares its nonzero qj and qk against cdb_q_i and ldb_q_i each cycle. On a match, capture the value and clear the tag. A value arriving in cycle N makes the entry eligible for issue in cycle N+1.
- Issue:
  - Each enabled cycle, the lowest-index ready entry, judged on pre-update state, is issued.
  - alu_en_o<=1 and alu_*_o are loaded from that entry; its valid bit is cleared at the same edge.
  - If no entry is ready, alu_en_o<=0 and the alu_*_o data fields hold their previous values.
  - Latency: an instruction dispatched with both tags 0 at edge N issues at edge N+1 (alu_en_o high after edge N+1). It never issues at its own insert edge.
- full_o: registered.
  - Equals 1 when the post-update count of valid entries is ≥ RS_N-1. This leaves one slot for the dispatch already in flight from the register file stage.
  - Dispatch while all RS_N entries are valid is an upstream protocol violation. The dispatch is dropped and no entry is corrupted.
- Simultaneous dispatch, wakeup, and issue in one cycle are all legal and independent. An issued entry is never also woken (it is ready, so both tags are already 0).
- Tag 0 is never matched against broadcasts, and entries never wrap or reorder. The count saturates only by construction.

Test Plan:
- Ready dispatch: rf_en_i with qj=qk=0, vj=5, vk=7, op=ADD, qd=3 -> one cycle later alu_en_o=1, alu_vj_o=5, alu_vk_o=7, alu_qd_o=3; next cycle alu_en_o=0.
- Wakeup: dispatch qj=2, vk=1, qk=0; 3 cycles later cdb_en_i with q=2, v=0x10 -> alu_en_o=1 on the following cycle with vj=0x10; no issue earlier.
- Insert-time bypass: dispatch qj=4 while ldb_en_i with q=4, v=0xAB is valid in the same cycle -> issue next cycle with vj=0xAB.
- Fill/full: 7 dispatches of blocked entries (qj=9) -> full_o=1 after the 7th; broadcast cdb q=9 -> 7 consecutive alu_en_o pulses in entry order; full_o drops after the first issue.
- Flush: 4 blocked entries, then br_flag pulse -> alu_en_o stays 0; later cdb q=9 produces no issue; full_o=0.
- Reset and stall: rst=0 mid-stream clears everything. With en=0 for 3 cycles while entries are ready, no issue happens; issue resumes on the first en=1 cycle.
